// File: rtl/bsg_wormhole_concentrator_test_pkg.sv
// Shared types for the wormhole concentrator test sequencer: run-state encoding
// and the per-node delta-versus-target comparison result.
package bsg_wormhole_concentrator_test_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_SEND  = 3'd1,
    SEQ_DRAIN = 3'd2,
    SEQ_CHECK = 3'd3,
    SEQ_DONE  = 3'd4
  } bsg_wh_conc_seq_state_e;

  // Where a node's counter delta sits relative to the per-run packet target.
  typedef enum logic [1:0] {
    DELTA_BELOW = 2'd0,
    DELTA_AT    = 2'd1,
    DELTA_ABOVE = 2'd2
  } bsg_wh_conc_delta_cmp_e;

endpackage

// File: rtl/bsg_wormhole_concentrator_test_rr_pick.sv
// Round-robin selector: grants the lowest-indexed needy node at or after the
// pointer, wrapping around. Used only by the throttled sequencer build.
module bsg_wormhole_concentrator_test_rr_pick #(
  parameter int unsigned width_p     = 4,
  parameter int unsigned ptr_width_p = 2
) (
  input  logic [width_p-1:0]     needy_i,
  input  logic [ptr_width_p-1:0] ptr_i,
  output logic [width_p-1:0]     grant_o,
  output logic [ptr_width_p-1:0] grant_idx_o,
  output logic                   grant_v_o
);

  always_comb begin
    int unsigned idx;
    grant_o     = '0;
    grant_idx_o = '0;
    grant_v_o   = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < width_p; k++) begin
      idx = (int'(ptr_i) + k) % width_p;
      if (!grant_v_o && needy_i[ptr_width_p'(idx)]) begin
        grant_v_o                  = 1'b1;
        grant_idx_o                = ptr_width_p'(idx);
        grant_o[ptr_width_p'(idx)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_wormhole_concentrator_test_sequencer.sv
// Run controller for a bank of wormhole concentrator test nodes: sends a fixed
// packet count per node, drains responses under a watchdog, reports the result.
// Define BSG_WH_CONC_SEQ_THROTTLE_EN to limit SEND to one enabled node per cycle.
module bsg_wormhole_concentrator_test_sequencer
  import bsg_wormhole_concentrator_test_pkg::*;
#(
  parameter int unsigned num_nodes_p    = 4,
  parameter int unsigned count_width_p  = 32,
  parameter int unsigned target_count_p = 64,
  parameter int unsigned timeout_p      = 4096
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   start_i,
  input  logic [num_nodes_p*count_width_p-1:0]   sent_i,
  input  logic [num_nodes_p*count_width_p-1:0]   received_i,
  input  logic [num_nodes_p-1:0]                 error_i,
  output logic [num_nodes_p-1:0]                 node_en_o,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   pass_o,
  output logic                                   timeout_o
);

  localparam int unsigned wd_width_lp = $clog2(timeout_p + 1);
  localparam logic [count_width_p-1:0] target_lp  = count_width_p'(target_count_p);
  localparam logic [wd_width_lp-1:0]   wd_last_lp = wd_width_lp'(timeout_p - 1);

  bsg_wh_conc_seq_state_e state_q, state_d;
  logic [count_width_p-1:0] sent_base_q [num_nodes_p];
  logic [count_width_p-1:0] recv_base_q [num_nodes_p];
  logic                     sticky_q, sticky_d;
  logic                     pass_q, pass_d;
  logic                     timeout_q, timeout_d;
  logic [wd_width_lp-1:0]   wd_q, wd_d;
  logic                     capture;
  logic                     in_send;

  logic [num_nodes_p-1:0] needy, sent_at, recv_at;

  function automatic bsg_wh_conc_delta_cmp_e cmp_delta(input logic [count_width_p-1:0] d);
    if (d < target_lp) return DELTA_BELOW;
    if (d == target_lp) return DELTA_AT;
    return DELTA_ABOVE;
  endfunction

  // Modulo subtraction makes counter wrap between runs harmless.
  for (genvar i = 0; i < num_nodes_p; i++) begin : g_node
    logic [count_width_p-1:0] sd, rd;
    assign sd         = sent_i[i*count_width_p +: count_width_p] - sent_base_q[i];
    assign rd         = received_i[i*count_width_p +: count_width_p] - recv_base_q[i];
    assign needy[i]   = (cmp_delta(sd) == DELTA_BELOW);
    assign sent_at[i] = (cmp_delta(sd) == DELTA_AT);
    assign recv_at[i] = (cmp_delta(rd) == DELTA_AT);
  end

  assign in_send = (state_q == SEQ_SEND);

`ifdef BSG_WH_CONC_SEQ_THROTTLE_EN
  localparam int unsigned ptr_width_lp = (num_nodes_p > 1) ? $clog2(num_nodes_p) : 1;
  localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(num_nodes_p - 1);

  logic [ptr_width_lp-1:0] ptr_q, ptr_d, grant_idx;
  logic [num_nodes_p-1:0]  grant;
  logic                    grant_v;

  bsg_wormhole_concentrator_test_rr_pick #(
    .width_p     (num_nodes_p),
    .ptr_width_p (ptr_width_lp)
  ) rr_pick (
    .needy_i     (needy),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_v_o   (grant_v)
  );

  assign node_en_o = in_send ? grant : '0;

  // The pointer moves past every grant, accepted or not: one shared slot per cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (in_send && grant_v) begin
      ptr_d = (grant_idx == ptr_last_lp) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end
`else
  assign node_en_o = in_send ? needy : '0;
`endif

  always_comb begin
    state_d   = state_q;
    sticky_d  = sticky_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    wd_d      = wd_q;
    capture   = 1'b0;
    unique case (state_q)
      SEQ_IDLE, SEQ_DONE: begin
        if (start_i) begin
          capture   = 1'b1;
          sticky_d  = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          wd_d      = '0;
          state_d   = SEQ_SEND;
        end
      end
      SEQ_SEND: begin
        sticky_d = sticky_q | (|error_i);
        if (&sent_at) state_d = SEQ_DRAIN;
      end
      SEQ_DRAIN: begin
        sticky_d = sticky_q | (|error_i);
        wd_d     = wd_q + 1'b1;
        // Completion takes priority over a simultaneous watchdog expiry.
        if (&recv_at) begin
          state_d = SEQ_CHECK;
        end else if (wd_q == wd_last_lp) begin
          state_d   = SEQ_DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
      end
      SEQ_CHECK: begin
        sticky_d = sticky_q | (|error_i);
        pass_d   = !sticky_q && !(|error_i) && (&sent_at) && (&recv_at);
        state_d  = SEQ_DONE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= SEQ_IDLE;
      sticky_q  <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
      for (int i = 0; i < num_nodes_p; i++) begin
        sent_base_q[i] <= '0;
        recv_base_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      sticky_q  <= sticky_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      wd_q      <= wd_d;
      if (capture) begin
        for (int i = 0; i < num_nodes_p; i++) begin
          sent_base_q[i] <= sent_i[i*count_width_p +: count_width_p];
          recv_base_q[i] <= received_i[i*count_width_p +: count_width_p];
        end
      end
    end
  end

  assign busy_o    = (state_q == SEQ_SEND) || (state_q == SEQ_DRAIN) || (state_q == SEQ_CHECK);
  assign done_o    = (state_q == SEQ_DONE);
  assign pass_o    = pass_q;
  assign timeout_o = timeout_q;

endmodule
